// File: rtl/npu_dma_pkg.sv
// Shared types and constants for the NPU AXI DMA copy engine.
// Optional 4 KB burst splitting is enabled by defining NPU_DMA_4K_SPLIT_EN.
package npu_dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP,
      S_DONE
   } state_e;

   localparam int         BEAT_BYTES   = 32;
   localparam logic [2:0] AXI_SIZE_32B = 3'd5;

   function automatic logic [31:0] min_beats(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/npu_dma_burst_buf.sv
// Store-and-forward burst buffer: DEPTH x DATA_W registers, one write port
// and one combinational read port.
module npu_dma_burst_buf #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 256,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // NOTE: storage is deliberately not reset; every entry is written by the
   // read phase before the write phase can read it back.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/npu_axi_dma_copy.sv
// AXI4 copy engine: splits one DMA_COPY request into store-and-forward bursts.
// Define NPU_DMA_4K_SPLIT_EN to keep every src/dst burst inside one 4 KB page.
module npu_axi_dma_copy
   import npu_dma_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 256,
   parameter int MAX_BURST = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dma_req_valid,
   output logic                dma_req_ready,
   input  logic [ADDR_W-1:0]   dma_req_src,
   input  logic [ADDR_W-1:0]   dma_req_dst,
   input  logic [31:0]         dma_req_bytes,
   output logic                dma_resp_done,
   output logic                busy,
   output logic                err,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [7:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wlast,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [7:0]          m_axi_arlen,
   output logic [2:0]          m_axi_arsize,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic                m_axi_rlast
);

   localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   state_e              state_q;
   logic [ADDR_W-1:0]   src_q, dst_q;
   logic [31:0]         rem_q;
   logic [7:0]          len_q, idx_q;
   logic                ready_q, done_q, busy_q, err_q;
   logic                arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [31:0]         beats_in, blen_cur, rem_step, plan_rem, lim;
   logic [ADDR_W-1:0]   src_in, dst_in, step, src_step, dst_step, plan_src, plan_dst;
   logic [7:0]          len_d;
   logic [IDX_W-1:0]    rd_addr;
   logic [DATA_W-1:0]   rd_data;
   logic                last_beat;

   // Request addresses are beat aligned and byte counts round up to whole beats.
   assign src_in   = dma_req_src & ~ADDR_W'(BEAT_BYTES - 1);
   assign dst_in   = dma_req_dst & ~ADDR_W'(BEAT_BYTES - 1);
   assign beats_in = 32'(({1'b0, dma_req_bytes} + 33'(BEAT_BYTES - 1)) / 33'(BEAT_BYTES));

   assign blen_cur = {24'd0, len_q} + 32'd1;
   assign step     = ADDR_W'(blen_cur) * ADDR_W'(BEAT_BYTES);
   assign src_step = src_q + step;
   assign dst_step = dst_q + step;
   assign rem_step = rem_q - blen_cur;

   // The next burst is planned either from a fresh request or from the advanced pointers.
   assign plan_src = (state_q == S_IDLE) ? src_in   : src_step;
   assign plan_dst = (state_q == S_IDLE) ? dst_in   : dst_step;
   assign plan_rem = (state_q == S_IDLE) ? beats_in : rem_step;

   always_comb begin
      lim = 32'(MAX_BURST);
`ifdef NPU_DMA_4K_SPLIT_EN
      lim = min_beats(lim, 32'd128 - 32'(plan_src[11:5]));
      lim = min_beats(lim, 32'd128 - 32'(plan_dst[11:5]));
`endif
      len_d = 8'(min_beats(plan_rem, lim) - 32'd1);
   end

   assign last_beat = (idx_q == len_q);
   assign rd_addr   = (state_q == S_WR_DATA) ? IDX_W'(idx_q + 8'd1) : '0;

   npu_dma_burst_buf #(
      .DEPTH  (MAX_BURST),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_buf (
      .clk   (clk),
      .we    (rready_q && m_axi_rvalid),
      .waddr (IDX_W'(idx_q)),
      .wdata (m_axi_rdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wlast_q   <= 1'b0;
         bready_q  <= 1'b0;
         wdata_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (dma_req_valid) begin
                  src_q   <= src_in;
                  dst_q   <= dst_in;
                  rem_q   <= beats_in;
                  err_q   <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (beats_in == 32'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= S_RD_ADDR;
                     len_q     <= len_d;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            S_RD_ADDR: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  idx_q     <= '0;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (m_axi_rvalid) begin
                  // The beat count ends the burst; a wrong rlast is only flagged.
                  if (m_axi_rlast != last_beat) err_q <= 1'b1;
                  if (last_beat) begin
                     rready_q  <= 1'b0;
                     awvalid_q <= 1'b1;
                     state_q   <= S_WR_ADDR;
                  end else begin
                     idx_q <= idx_q + 8'd1;
                  end
               end
            end
            S_WR_ADDR: begin
               if (m_axi_awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  idx_q     <= '0;
                  wdata_q   <= rd_data;
                  wlast_q   <= (len_q == 8'd0);
                  state_q   <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (m_axi_wready) begin
                  if (wlast_q) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     bready_q <= 1'b1;
                     state_q  <= S_WR_RESP;
                  end else begin
                     idx_q   <= idx_q + 8'd1;
                     wdata_q <= rd_data;
                     wlast_q <= ((idx_q + 8'd1) == len_q);
                  end
               end
            end
            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  bready_q <= 1'b0;
                  src_q    <= src_step;
                  dst_q    <= dst_step;
                  rem_q    <= rem_step;
                  if (rem_step == 32'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= S_RD_ADDR;
                     len_q     <= len_d;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dma_req_ready = ready_q;
   assign dma_resp_done = done_q;
   assign busy          = busy_q;
   assign err           = err_q;

   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = src_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = AXI_SIZE_32B;
   assign m_axi_rready  = rready_q;

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = dst_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = AXI_SIZE_32B;

   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = wlast_q;
   assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_npu_axi_dma_copy.sv
// Directed bench for npu_axi_dma_copy with an AXI memory responder.
// Expectations follow NPU_DMA_4K_SPLIT_EN when it is defined for the build.
module tb_npu_axi_dma_copy;

   logic         clk, rst;
   logic         dma_req_valid, dma_req_ready;
   logic [63:0]  dma_req_src, dma_req_dst;
   logic [31:0]  dma_req_bytes;
   logic         dma_resp_done, busy, err;
   logic         m_axi_awvalid, m_axi_awready;
   logic [63:0]  m_axi_awaddr;
   logic [7:0]   m_axi_awlen;
   logic [2:0]   m_axi_awsize;
   logic         m_axi_wvalid, m_axi_wready;
   logic [255:0] m_axi_wdata;
   logic [31:0]  m_axi_wstrb;
   logic         m_axi_wlast;
   logic         m_axi_bvalid, m_axi_bready;
   logic         m_axi_arvalid, m_axi_arready;
   logic [63:0]  m_axi_araddr;
   logic [7:0]   m_axi_arlen;
   logic [2:0]   m_axi_arsize;
   logic         m_axi_rvalid, m_axi_rready;
   logic [255:0] m_axi_rdata;
   logic         m_axi_rlast;

   npu_axi_dma_copy dut (
      .clk           (clk),
      .rst           (rst),
      .dma_req_valid (dma_req_valid),
      .dma_req_ready (dma_req_ready),
      .dma_req_src   (dma_req_src),
      .dma_req_dst   (dma_req_dst),
      .dma_req_bytes (dma_req_bytes),
      .dma_resp_done (dma_resp_done),
      .busy          (busy),
      .err           (err),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awlen   (m_axi_awlen),
      .m_axi_awsize  (m_axi_awsize),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wlast   (m_axi_wlast),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rlast   (m_axi_rlast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Source memory content is a pure function of the byte address.
   function automatic logic [255:0] pat(input logic [63:0] a);
      return {a ^ 64'hDEAD_BEEF_0000_0000, ~a, a + 64'h1111, {a[31:0], a[63:32]}};
   endfunction

   logic [255:0] dst_mem [logic [63:0]];
   logic [63:0]  ar_addr [64];
   logic [63:0]  aw_addr [64];
   int           ar_len  [64];
   int           aw_len  [64];
   int  cyc = 0, done_cnt = 0, done_cyc = 0, b_cyc = 0, done_wide = 0;
   int  ar_cnt = 0, aw_cnt = 0, w_cnt = 0, av_seen = 0, last_wbeat = 0;
   int  stab_bad = 0, wlast_bad = 0, proto_bad = 0;
   bit  bp = 0, bad_rlast = 0;

   function automatic logic rnd();
      return bp ? ($urandom_range(0, 1) == 1) : 1'b1;
   endfunction

   // AXI memory responder and protocol monitor, all work done on the falling edge.
   initial begin
      logic [63:0]  p_araddr, p_awaddr, r_base, w_base;
      logic [7:0]   p_arlen, p_awlen;
      logic [255:0] p_wdata;
      logic         p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_wlast, p_done;
      logic         r_active, w_active, b_pending;
      int           r_beat, r_len, w_beat, w_len;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_done = 0;
      p_araddr = '0; p_awaddr = '0; p_arlen = '0; p_awlen = '0; p_wdata = '0; p_wlast = 0;
      r_active = 0; w_active = 0; b_pending = 0;
      r_beat = 0; r_len = 0; w_beat = 0; w_len = 0; r_base = '0; w_base = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (dma_resp_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (p_done) done_wide++;
         end
         p_done = dma_resp_done;
         if (m_axi_arvalid || m_axi_awvalid) av_seen++;
         if (rst) begin
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
            m_axi_wready = 0; m_axi_bvalid = 0;
            p_arv = 0; p_awv = 0; p_wv = 0;
            r_active = 0; w_active = 0; b_pending = 0;
            continue;
         end
         if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_araddr || m_axi_arlen !== p_arlen))
            stab_bad++;
         if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr || m_axi_awlen !== p_awlen))
            stab_bad++;
         if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wlast !== p_wlast))
            stab_bad++;

         m_axi_arready = rnd();
         if (m_axi_arvalid && m_axi_arready) begin
            if (ar_cnt < 64) begin
               ar_addr[ar_cnt] = m_axi_araddr;
               ar_len[ar_cnt]  = int'(m_axi_arlen);
            end
            ar_cnt++;
            r_active = 1; r_base = m_axi_araddr; r_len = int'(m_axi_arlen); r_beat = 0;
         end
         p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr; p_arlen = m_axi_arlen;

         if (r_active) begin
            m_axi_rvalid = rnd();
            m_axi_rdata  = pat(r_base + 64'(r_beat) * 64'd32);
            m_axi_rlast  = bad_rlast ? 1'b0 : (r_beat == r_len);
            if (m_axi_rvalid && m_axi_rready) begin
               r_beat++;
               if (r_beat > r_len) r_active = 0;
            end
         end else begin
            m_axi_rvalid = 0;
            if (m_axi_rready) proto_bad++;
         end

         m_axi_awready = rnd();
         if (m_axi_awvalid && m_axi_awready) begin
            if (aw_cnt < 64) begin
               aw_addr[aw_cnt] = m_axi_awaddr;
               aw_len[aw_cnt]  = int'(m_axi_awlen);
            end
            aw_cnt++;
            w_active = 1; w_base = m_axi_awaddr; w_len = int'(m_axi_awlen); w_beat = 0;
         end
         p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;

         m_axi_wready = rnd();
         if (m_axi_wvalid && m_axi_wready) begin
            if (!w_active) proto_bad++;
            dst_mem[w_base + 64'(w_beat) * 64'd32] = m_axi_wdata;
            if (m_axi_wlast !== (w_beat == w_len)) wlast_bad++;
            if (m_axi_wlast) last_wbeat = w_beat + 1;
            w_cnt++;
            w_beat++;
            if (w_beat > w_len) begin
               w_active  = 0;
               b_pending = 1;
            end
         end
         p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wlast = m_axi_wlast;

         if (b_pending) begin
            m_axi_bvalid = rnd();
            if (m_axi_bvalid && m_axi_bready) begin
               b_pending = 0;
               b_cyc = cyc;
            end
         end else begin
            m_axi_bvalid = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int req_cyc = 0;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; done_cnt = 0; av_seen = 0; last_wbeat = 0;
      dst_mem.delete();
   endtask

   task automatic do_req(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] bytes);
      step();
      clear_stats();
      chk("req_ready_idle", dma_req_ready, 1'b1);
      dma_req_valid = 1; dma_req_src = src; dma_req_dst = dst; dma_req_bytes = bytes;
      req_cyc = cyc;
      step();
      dma_req_valid = 0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin
         step();
         n++;
      end
      chk({tag, "_done_seen"}, done_cnt > 0, 1'b1);
      repeat (3) step();
      chk({tag, "_done_once"}, done_cnt, 1);
   endtask

   task automatic check_copy(input string tag, input logic [63:0] src, input logic [63:0] dst, input int beats);
      int nbad = 0;
      for (int k = 0; k < beats; k++) begin
         logic [63:0] da;
         da = dst + 64'(k) * 64'd32;
         if (!dst_mem.exists(da) || dst_mem[da] !== pat(src + 64'(k) * 64'd32)) nbad++;
      end
      chk({tag, "_data"}, nbad, 0);
   endtask

   initial begin
      int nbad;
      rst = 1; dma_req_valid = 0; dma_req_src = '0; dma_req_dst = '0; dma_req_bytes = '0;
      repeat (3) step();
      chk("rst_ready", dma_req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", dma_resp_done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
      chk("rst_araddr", m_axi_araddr, 64'd0);
      chk("rst_awaddr", m_axi_awaddr, 64'd0);
      chk("rst_lens", {m_axi_arlen, m_axi_awlen}, 16'd0);
      chk("rst_size", {m_axi_arsize, m_axi_awsize}, {3'd5, 3'd5});
      chk("rst_wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
      chk("rst_wdata", m_axi_wdata, 256'd0);
      rst = 0;

      // 256 B single burst
      do_req(64'h0, 64'h10_0000, 32'd256);
      wait_done("t256", 200);
      chk("t256_ar_cnt", ar_cnt, 1);
      chk("t256_arlen", ar_len[0], 7);
      chk("t256_araddr", ar_addr[0], 64'h0);
      chk("t256_aw_cnt", aw_cnt, 1);
      chk("t256_awlen", aw_len[0], 7);
      chk("t256_awaddr", aw_addr[0], 64'h10_0000);
      chk("t256_w_cnt", w_cnt, 8);
      chk("t256_wlast_beat", last_wbeat, 8);
      chk("t256_b_to_done", done_cyc - b_cyc, 1);
      chk("t256_err", err, 1'b0);
      check_copy("t256", 64'h0, 64'h10_0000, 8);

      // 4096 B, eight full bursts
      do_req(64'h2000, 64'h8000, 32'd4096);
      wait_done("t4k", 2000);
      chk("t4k_ar_cnt", ar_cnt, 8);
      chk("t4k_aw_cnt", aw_cnt, 8);
      nbad = 0;
      for (int i = 0; i < 8; i++) begin
         if (ar_len[i] != 15 || aw_len[i] != 15) nbad++;
         if (ar_addr[i] != 64'h2000 + 64'(i) * 64'h200) nbad++;
         if (aw_addr[i] != 64'h8000 + 64'(i) * 64'h200) nbad++;
      end
      chk("t4k_bursts", nbad, 0);
      check_copy("t4k", 64'h2000, 64'h8000, 128);

      // zero bytes: no AXI traffic
      do_req(64'h1234, 64'h5678, 32'd0);
      wait_done("tzero", 20);
      chk("tzero_latency_le2", (done_cyc - req_cyc) >= 1 && (done_cyc - req_cyc) <= 2, 1'b1);
      chk("tzero_no_axi", av_seen, 0);
      chk("tzero_err", err, 1'b0);

      // random backpressure, 1000 B rounds up to 32 beats, low address bits dropped
      bp = 1;
      do_req(64'h4_001F, 64'h6_0005, 32'd1000);
      wait_done("tbp", 5000);
      bp = 0;
      chk("tbp_ar_cnt", ar_cnt, 2);
      chk("tbp_araddr0", ar_addr[0], 64'h4_0000);
      chk("tbp_awaddr1", aw_addr[1], 64'h6_0200);
      chk("tbp_w_cnt", w_cnt, 32);
      check_copy("tbp", 64'h4_0000, 64'h6_0000, 32);

      // rlast never asserted: err is raised but the beat count still governs
      bad_rlast = 1;
      do_req(64'h5000, 64'hA000, 32'd64);
      wait_done("trlast", 200);
      bad_rlast = 0;
      chk("trlast_err", err, 1'b1);
      check_copy("trlast", 64'h5000, 64'hA000, 2);

      // 4 KB crossing source; a new accept also clears err
      do_req(64'hFC0, 64'h2_0000, 32'd256);
      chk("t4kx_err_cleared", err, 1'b0);
      wait_done("t4kx", 400);
`ifdef NPU_DMA_4K_SPLIT_EN
      chk("t4kx_ar_cnt", ar_cnt, 2);
      chk("t4kx_len0", ar_len[0], 1);
      chk("t4kx_len1", ar_len[1], 5);
      chk("t4kx_addr1", ar_addr[1], 64'h1000);
`else
      chk("t4kx_ar_cnt", ar_cnt, 1);
      chk("t4kx_len0", ar_len[0], 7);
`endif
      check_copy("t4kx", 64'hFC0, 64'h2_0000, 8);

      // reset during WR_DATA, then a fresh request
      do_req(64'h6000, 64'hC000, 32'd512);
      nbad = 0;
      while (w_cnt < 3 && nbad < 200) begin
         step();
         nbad++;
      end
      chk("trst_in_wr_data", m_axi_wvalid && w_cnt >= 3, 1'b1);
      rst = 1;
      step();
      chk("trst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
      chk("trst_busy", busy, 1'b0);
      chk("trst_ready", dma_req_ready, 1'b1);
      rst = 0;
      do_req(64'h3000, 64'h9000, 32'd64);
      wait_done("tfresh", 200);
      chk("tfresh_ar_cnt", ar_cnt, 1);
      chk("tfresh_len", aw_len[0], 1);
      chk("tfresh_err", err, 1'b0);
      check_copy("tfresh", 64'h3000, 64'h9000, 2);

      chk("valid_stability", stab_bad, 0);
      chk("wlast_position", wlast_bad, 0);
      chk("done_single_cycle", done_wide, 0);
      chk("channel_protocol", proto_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
